// File: rtl/pipe_skid_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg_if
//   Valid/ready/data handshake bundle used on both sides of pipe_skid_reg.
//
//   Signals:
//     valid  producer -> consumer   payload valid
//     ready  consumer -> producer   consumer can accept
//     data   producer -> consumer   payload, WIDTH bits
//
//   Modports:
//     master  the producing side (drives valid/data, observes ready)
//     slave   the consuming side (observes valid/data, drives ready)
// -----------------------------------------------------------------------------
interface pipe_skid_reg_if #(
    parameter int unsigned WIDTH = 65
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
//   Pipeline register stage with valid/ready back-pressure and a 2-entry skid
//   buffer. Sustains one beat per cycle while keeping in_ready a pure register
//   output, so no combinational path crosses the stage in either direction.
//
//   Optional feature (macro PIPE_SKID_STALL_CNT_EN):
//     adds a saturating stall counter and the stall_cnt output port.
//
//   Parameters:
//     WIDTH      payload bits per entry
//     RESET_VAL  value loaded into both data registers on reset/softReset
//     CNT_W      stall counter width (only with PIPE_SKID_STALL_CNT_EN)
//
//   Ports:
//     clk        single clock, all state changes on posedge
//     reset      synchronous active-high full clear (stall_cnt included)
//     softReset  synchronous active-high flush; drops both entries and any
//                transfer in the same cycle, stall_cnt holds
//     up         upstream handshake (in_valid/in_ready/in_data), slave side
//     dn         downstream handshake (out_valid/out_ready/out_data), master
//     stall_cnt  cycles with out_valid & !out_ready, saturating
// -----------------------------------------------------------------------------
module pipe_skid_reg #(
    parameter int unsigned      WIDTH     = 65,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    parameter int unsigned      CNT_W     = 16
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            softReset,
    pipe_skid_reg_if.slave  up,
    pipe_skid_reg_if.master dn
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    // Encoding is {main_valid, skid_valid}; (0,1) is unreachable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;

    logic w_in_fire;
    logic w_out_fire;

    // All handshake outputs are straight register bits.
    assign up.ready = ~r_state[0];
    assign dn.valid = r_state[1];
    assign dn.data  = r_main_data;

    assign w_in_fire  = up.valid & up.ready;
    assign w_out_fire = dn.valid & dn.ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset || softReset) begin
            // Flush and full reset clear the same state; only the stall
            // counter tells them apart. Any transfer this cycle is dropped.
            r_state     <= ST_EMPTY;
            // NOTE: the data registers are reset explicitly so out_data shows
            // RESET_VAL rather than stale payload after a clear.
            r_main_data <= RESET_VAL;
            r_skid_data <= RESET_VAL;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_main_data <= up.data;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        // Pass-through: main is refilled, skid stays unused.
                        r_main_data <= up.data;
                    end else if (w_in_fire) begin
                        r_skid_data <= up.data;
                        r_state     <= ST_FULL;
                    end else if (w_out_fire) begin
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (w_out_fire) begin
                        r_main_data <= r_skid_data;
                        r_state     <= ST_ONE;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

`ifdef PIPE_SKID_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (!softReset && dn.valid && !dn.ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    // Upstream must hold in_data while a stalled beat is being offered.
    a_in_data_stable: assert property (
        @(posedge clk) disable iff (reset)
        (up.valid && !up.ready) |=> (!up.valid || $stable(up.data))
    );

    a_state_legal: assert property (
        @(posedge clk) r_state inside {ST_EMPTY, ST_ONE, ST_FULL}
    );

endmodule
